pwm_multichannel: RTL and testbench
===================================

Name: pwm_multichannel

Overview:
N-channel PWM generator running entirely on clkCore. It replaces two-clock beat-frequency PWM generation with a shared single-clock period counter and per-channel compare.
- Each channel has a programmable duty and phase offset.
- Programming goes through a valid/ready write port into shadow registers.
- Shadow values commit atomically at frame wrap.
- It drives the photonic-switch modulator lines.

Parameters:
N_CH, 4, number of PWM channels (1..16)
CNT_W, 8, width of period/duty/phase values and frame counter
DEADTIME, 2, clkCore cycles of dead time on complementary outputs (used only with PWM_COMPL_EN)

Ports:
clkCore  in  1  core clock (200 MHz)
reset  in  1  synchronous, active-high reset
en  in  1  run enable; low = counter parked, outputs low
period  in  CNT_W  frame length minus 1; sampled at commit
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready at rising clkCore
wr_ch  in  $clog2(N_CH) (min 1)  target channel
wr_duty  in  CNT_W  high-time in cycles
wr_phase  in  CNT_W  phase offset in cycles
pwm_out  out  N_CH  registered PWM outputs
frame_start  out  1  one-cycle pulse on the cycle cnt==0 (debug/sync)
cnt  out  CNT_W  frame counter value (debug)

Behaviour:
- Reset (sync, high): cnt=0; period_act=0; all shadow/active duty and phase=0; pwm_out=0; frame_start=0; wr_ready=0. Reset mid-frame discards pending shadow writes.
- Frame counter, en=1: cnt increments each cycle.
  - At cnt==period_act, next cnt=0 (wrap). This is the "commit cycle".
  - CNT_W arithmetic is unsigned and modulo 2^CNT_W. period=2^CNT_W-1 gives a full-range frame.
- Commit, on the commit cycle: period_act<=period; every channel's active duty/phase<=shadow. All channels update in the same cycle.
- Compare, per channel:
  - rel = cnt-phase if cnt>=phase, else cnt+period_act+1-phase.
  - Next pwm_out[i] = (rel < duty).
  - pwm_out is registered, one cycle behind cnt.
  - duty==0: always low. duty>period_act: always high.
  - phase>period_act: treated as phase 0.
- Write port:
  - wr_ready=1 except during reset and on the commit cycle.
  - An accepted write loads shadow duty/phase of wr_ch.
  - A write with wr_ch>=N_CH is accepted and dropped.
  - Repeated writes to one channel within a frame: last one wins.
  - A written value reaches pwm_out on the first frame after the next commit.
- en=0:
  - cnt held at 0; pwm_out=0; frame_start=0.
  - Shadows commit to active every cycle; wr_ready=1.
  - On en rising, the frame starts at cnt=0 with the latest values.
- frame_start: registered, high for exactly one cycle per frame, aligned with the pwm_out cycle derived from cnt==0.

Optional Feature:
PWM_COMPL_EN
- Defined: adds output pwm_out_n [N_CH], the complement of pwm_out with DEADTIME cycles of dead time.
  - Each rising edge of pwm_out is delayed DEADTIME cycles; pwm_out_n falls immediately.
  - Each rising edge of pwm_out_n is delayed DEADTIME cycles after pwm_out falls.
  - Pulses shorter than or equal to DEADTIME are suppressed.
  - Both outputs are low in reset and while en=0.
- Not defined: no pwm_out_n port; no dead-time logic synthesised.

Decomposition:
- Package pwm_pkg: CNT_W default constant, cnt_t typedef, ch_idx_t typedef, per-channel config struct {duty, phase}.
- Sub-module pwm_channel: one channel's shadow/active registers, phase-relative compare, output register and, under PWM_COMPL_EN, dead-time logic.
- Top level: frame counter, commit strobe, write decode, generate loop over N_CH.

Test Plan:
- Reset while running, then release with period=9, ch0 duty=3 phase=0, en=1 -> pwm_out[0] high 3 cycles, low 7, frame_start every 10 cycles.
- ch1 duty=4 phase=8, period=9 -> ch1 high at cnt 8,9,0,1 (one cycle later at pwm_out); ch0 unaffected.
- Mid-frame write ch0 duty=7 -> current frame still duty 3, next frame duty 7. A write on the commit cycle sees wr_ready=0 and retries next cycle.
- Edge values: duty=0 -> constant low; duty=10 with period=9 -> constant high; phase=12 -> behaves as phase 0; wr_ch=N_CH -> no channel changes.
- en toggled low mid-frame -> outputs 0 next cycle, cnt=0. Re-enable -> frame restarts at cnt=0 with values written while disabled.
- With PWM_COMPL_EN, DEADTIME=2, duty=5, period=9 -> pwm_out high 3 cycles, pwm_out_n high 3 cycles, 2-cycle gaps with both low. Duty=2 -> pwm_out never high.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, index and per-channel config types for the PWM block
package pwm_pkg;
  localparam int CNT_W_DEF = 8;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef logic [3:0] ch_idx_t;
  typedef struct packed {
    cnt_t duty;
    cnt_t phase;
  } ch_cfg_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: shadow/active duty+phase, phase-relative compare and output register
// PWM_COMPL_EN adds a dead-timed complementary output pwm_out_n
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef PWM_COMPL_EN
  , parameter int DEADTIME = 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] period_act,
  input  logic             commit,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [CNT_W-1:0] wr_phase,
`ifdef PWM_COMPL_EN
  output logic             pwm_out_n,
`endif
  output logic             pwm_out
);
  typedef struct packed {
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] phase;
  } cfg_t;
  cfg_t shadow, shadow_nxt, active;
  logic [CNT_W-1:0] ph, rel;
  logic hit;
  // Commit takes the same-cycle write so a write while disabled is live on en rising
  always_comb begin
    shadow_nxt = wr_en ? {wr_duty, wr_phase} : shadow;
    ph = active.phase > period_act ? '0 : active.phase;
    rel = cnt >= ph ? cnt - ph : cnt + period_act + CNT_W'(1) - ph;
    hit = en && rel < active.duty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      shadow <= shadow_nxt;
      active <= commit ? shadow_nxt : active;
    end
  end
`ifdef PWM_COMPL_EN
  localparam int DW = $clog2(DEADTIME + 2);
  logic raw, run;
  logic [DW-1:0] held;
  // held counts cycles raw has kept its level, saturating at DEADTIME
  always_ff @(posedge clk) begin
    if (rst) begin
      raw <= 1'b0;
      run <= 1'b0;
      held <= '0;
    end else begin
      raw <= hit;
      run <= en;
      held <= (!en || hit != raw) ? '0 : held == DW'(DEADTIME) ? held : held + DW'(1);
    end
  end
  assign pwm_out = raw && held == DW'(DEADTIME);
  assign pwm_out_n = run && !raw && held == DW'(DEADTIME);
`else
  always_ff @(posedge clk) pwm_out <= rst ? 1'b0 : hit;
`endif
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel single-clock PWM with shadowed duty/phase committed at frame wrap
// PWM_COMPL_EN adds dead-timed complementary outputs pwm_out_n
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEADTIME = 2,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clkCore,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [CNT_W-1:0] wr_phase,
  output logic [N_CH-1:0]  pwm_out,
`ifdef PWM_COMPL_EN
  output logic [N_CH-1:0]  pwm_out_n,
`endif
  output logic             frame_start,
  output logic [CNT_W-1:0] cnt
);
  if (N_CH < 1 || N_CH > 16 || DEADTIME < 0) begin : g_bad_cfg
    $error("pwm_multichannel: N_CH must be 1..16 and DEADTIME non-negative");
  end
  logic [CNT_W-1:0] period_act;
  logic wrap, commit, wr_acc;
  // While disabled every cycle commits, so shadows pass straight to active
  assign wrap = cnt == period_act;
  assign commit = !en || wrap;
  assign wr_ready = !reset && !(en && wrap);
  assign wr_acc = wr_valid && wr_ready;
  always_ff @(posedge clkCore) begin
    if (reset) begin
      cnt <= '0;
      period_act <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt <= (en && !wrap) ? cnt + CNT_W'(1) : '0;
      period_act <= commit ? period : period_act;
      frame_start <= en && cnt == '0;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
`ifdef PWM_COMPL_EN
      , .DEADTIME(DEADTIME)
`endif
    ) u_ch (
      .clk(clkCore),
      .rst(reset),
      .en(en),
      .cnt(cnt),
      .period_act(period_act),
      .commit(commit),
      .wr_en(wr_acc && wr_ch == CH_W'(i)),
      .wr_duty(wr_duty),
      .wr_phase(wr_phase),
`ifdef PWM_COMPL_EN
      .pwm_out_n(pwm_out_n[i]),
`endif
      .pwm_out(pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed checks of framing, shadow commit, write handshake and edge values
module tb_pwm_multichannel;
  logic clkCore = 1'b0;
  logic reset, en, wr_valid, wr_ready, frame_start;
  logic [7:0] period, wr_duty, wr_phase, cnt;
  logic [1:0] wr_ch;
  logic [2:0] pwm_out;
`ifdef PWM_COMPL_EN
  logic [2:0] pwm_out_n;
`endif
  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] c0, c1, c2, fs, rdy;
  int acc_j, waited;

  pwm_multichannel #(.N_CH(3), .CNT_W(8), .DEADTIME(2)) dut (
    .clkCore(clkCore),
    .reset(reset),
    .en(en),
    .period(period),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_ch(wr_ch),
    .wr_duty(wr_duty),
    .wr_phase(wr_phase),
    .pwm_out(pwm_out),
`ifdef PWM_COMPL_EN
    .pwm_out_n(pwm_out_n),
`endif
    .frame_start(frame_start),
    .cnt(cnt)
  );

  always #5 clkCore = ~clkCore;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clkCore);
    #1;
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] p);
    int k = 0;
    wr_ch = ch;
    wr_duty = d;
    wr_phase = p;
    wr_valid = 1'b1;
    while (!wr_ready && k < 20) begin
      step();
      k++;
    end
    if (!wr_ready) check("wr_timeout", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  // Sample j holds pwm_out derived from cnt==j; optional write raised at sample wr_j
  task automatic capture(input int wr_j, input logic [1:0] ch, input logic [7:0] d, input logic [7:0] p);
    waited = 0;
    acc_j = -1;
    while (!frame_start && waited < 40) begin
      step();
      waited++;
    end
    if (!frame_start) check("fs_timeout", {31'd0, frame_start}, 32'd1);
    for (int j = 0; j < 10; j++) begin
      if (acc_j >= 0) wr_valid = 1'b0;
      if (j == wr_j) begin
        wr_ch = ch;
        wr_duty = d;
        wr_phase = p;
        wr_valid = 1'b1;
      end
      c0[j] = pwm_out[0];
      c1[j] = pwm_out[1];
      c2[j] = pwm_out[2];
      fs[j] = frame_start;
      rdy[j] = wr_ready;
      if (wr_valid && wr_ready && acc_j < 0) acc_j = j;
      step();
    end
    if (acc_j >= 0) wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    period = 8'd9;
    wr_valid = 1'b0;
    wr_ch = 2'd0;
    wr_duty = 8'd0;
    wr_phase = 8'd0;
    step();
    step();
    check("rst_cnt", cnt, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ready", wr_ready, 0);
    reset = 1'b0;
    step();
    check("dis_ready", wr_ready, 1);
    write(2'd0, 8'd3, 8'd0);
    write(2'd1, 8'd4, 8'd8);
    en = 1'b1;
    step();
    check("fs_first", frame_start, 1);
    check("cnt_at_fs", cnt, 1);
    capture(-1, 2'd0, 8'd0, 8'd0);
    check("f1_fs", fs, 10'h001);
    check("f1_ch0", c0, 10'h007);
    check("f1_ch1", c1, 10'h303);
    check("f1_ch2", c2, 10'h000);
    capture(4, 2'd0, 8'd7, 8'd0);
    check("f2_period", waited, 0);
    check("f2_acc", acc_j, 4);
    check("f2_ch0_old", c0, 10'h007);
    check("f2_ch1", c1, 10'h303);
    capture(8, 2'd1, 8'd2, 8'd0);
    check("f3_ready", rdy, 10'h2ff);
    check("f3_acc_retry", acc_j, 9);
    check("f3_ch0_new", c0, 10'h07f);
    check("f3_ch1", c1, 10'h303);
    capture(-1, 2'd0, 8'd0, 8'd0);
    check("f4_ch1_old", c1, 10'h303);
    check("f4_ch0", c0, 10'h07f);
    capture(-1, 2'd0, 8'd0, 8'd0);
    check("f5_ch1_new", c1, 10'h003);
    check("f5_ch0", c0, 10'h07f);
    step();
    step();
    step();
    check("pre_dis_ch0", pwm_out[0], 1);
    en = 1'b0;
    step();
    check("dis_pwm", pwm_out, 0);
    check("dis_cnt", cnt, 0);
    check("dis_fs", frame_start, 0);
    check("dis_ready2", wr_ready, 1);
    write(2'd0, 8'd0, 8'd0);
    write(2'd1, 8'd10, 8'd0);
    write(2'd2, 8'd3, 8'd12);
    write(2'd3, 8'd5, 8'd5);
    en = 1'b1;
    step();
    capture(-1, 2'd0, 8'd0, 8'd0);
    check("f6_fs", fs, 10'h001);
    check("f6_duty0", c0, 10'h000);
    check("f6_duty_over", c1, 10'h3ff);
    check("f6_phase_over", c2, 10'h007);
    step();
    step();
    write(2'd0, 8'd5, 8'd0);
    reset = 1'b1;
    en = 1'b0;
    step();
    check("rst2_cnt", cnt, 0);
    check("rst2_pwm", pwm_out, 0);
    check("rst2_fs", frame_start, 0);
    check("rst2_ready", wr_ready, 0);
    reset = 1'b0;
    step();
    en = 1'b1;
    step();
    capture(-1, 2'd0, 8'd0, 8'd0);
    check("f7_fs", fs, 10'h001);
    check("f7_ch0_discard", c0, 10'h000);
    check("f7_ch1_cleared", c1, 10'h000);
    capture(-1, 2'd0, 8'd0, 8'd0);
    check("f8_period", waited, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
